alu_muldiv: RTL and testbench

//  Parametrised, registered MIPS-style integer ALU with an iterative multiply/divide unit and HI/LO registers.

---
 rtl/alu_muldiv_pkg.sv | 32 +++
 rtl/alu_muldiv_muldiv_unit.sv | 146 ++++++++++++++
 rtl/alu_muldiv.sv | 121 ++++++++++++
 tb/tb_alu_muldiv.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_pkg.sv
// Shared opcode values and multiply/divide FSM states for the EX-stage ALU.
package alu_muldiv_pkg;

    localparam logic [4:0] OP_NOP   = 5'h00;
    localparam logic [4:0] OP_ADD   = 5'h01;
    localparam logic [4:0] OP_SUB   = 5'h02;
    localparam logic [4:0] OP_AND   = 5'h03;
    localparam logic [4:0] OP_OR    = 5'h04;
    localparam logic [4:0] OP_NOR   = 5'h05;
    localparam logic [4:0] OP_SLT   = 5'h06;
    localparam logic [4:0] OP_SLL   = 5'h07;
    localparam logic [4:0] OP_SRL   = 5'h08;
    localparam logic [4:0] OP_SRA   = 5'h09;
    localparam logic [4:0] OP_SLTU  = 5'h0A;
    localparam logic [4:0] OP_XOR   = 5'h0B;
    localparam logic [4:0] OP_MULT  = 5'h0C;
    localparam logic [4:0] OP_MULTU = 5'h0D;
    localparam logic [4:0] OP_DIV   = 5'h0E;
    localparam logic [4:0] OP_DIVU  = 5'h0F;
    localparam logic [4:0] OP_MFHI  = 5'h10;
    localparam logic [4:0] OP_MFLO  = 5'h11;
    localparam logic [4:0] OP_ADDU  = 5'h12;
    localparam logic [4:0] OP_SUBU  = 5'h13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

endpackage

// File: rtl/alu_muldiv_muldiv_unit.sv
// Iterative multiply/divide: operands are reduced to magnitudes at start, a shift-add multiplier
// or restoring divider runs WIDTH steps, and one FIX cycle applies signs and writes HI/LO.
module alu_muldiv_muldiv_unit
    import alu_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    md_state_e        state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    // acc holds the upper product half / partial remainder; work holds multiplier / quotient
    logic [WIDTH-1:0] acc_q, acc_d, work_q, work_d, opb_q, opb_d, opa_q, opa_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, bz_q, bz_d;

    logic             sa, sb;
    logic [WIDTH:0]   add_sum, mul_sel, rem_sh;
    logic [WIDTH+1:0] rem_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_FIX);
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Next-state: operand capture, one iteration step per cycle, sign fix on completion
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        work_d  = work_q;
        opb_d   = opb_q;
        opa_d   = opa_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        bz_d    = bz_q;

        sa       = signed_op & a[WIDTH-1];
        sb       = signed_op & b[WIDTH-1];
        add_sum  = {1'b0, acc_q} + {1'b0, opb_q};
        mul_sel  = work_q[0] ? add_sum : {1'b0, acc_q};
        rem_sh   = {acc_q, work_q[WIDTH-1]};
        // Extra top bit acts as the borrow flag of the trial subtraction
        rem_diff = {1'b0, rem_sh} - {2'b00, opb_q};
        prod     = {acc_q, work_q};
        prod_fix = neg_q ? -prod : prod;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = is_div ? ST_DIV : ST_MUL;
                    cnt_d   = '0;
                    acc_d   = '0;
                    work_d  = sa ? -a : a;
                    opb_d   = sb ? -b : b;
                    opa_d   = a;
                    div_d   = is_div;
                    neg_d   = sa ^ sb;
                    rneg_d  = sa;
                    bz_d    = (b == '0);
                end
            end
            ST_MUL: begin
                acc_d  = mul_sel[WIDTH:1];
                work_d = {mul_sel[0], work_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) state_d = ST_FIX;
            end
            ST_DIV: begin
                if (!rem_diff[WIDTH+1]) begin
                    acc_d  = rem_diff[WIDTH-1:0];
                    work_d = {work_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d  = rem_sh[WIDTH-1:0];
                    work_d = {work_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (bz_q) begin
                    // Divide by zero: fixed pattern, dividend passed through
                    lo_d = '1;
                    hi_d = opa_q;
                end else begin
                    lo_d = neg_q ? -work_q : work_q;
                    hi_d = rneg_q ? -acc_q : acc_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            work_q  <= '0;
            opb_q   <= '0;
            opa_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            bz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            work_q  <= work_d;
            opb_q   <= opb_d;
            opa_q   <= opa_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            bz_q    <= bz_d;
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Registered EX-stage ALU with valid/ready issue and an iterative multiply/divide unit.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned CTRL_W  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  alu_ctrl,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               ovf
);

    logic             busy, md_done, accept, is_md;
    logic [WIDTH-1:0] hi, lo, sum, dif, op_res;
    logic             op_ovf;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, ovf_q, ovf_d, out_valid_q, out_valid_d;

    assign in_ready  = ~busy;
    assign accept    = in_valid & ~busy;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

    alu_muldiv_muldiv_unit #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept & is_md),
        .signed_op((alu_ctrl == OP_MULT) || (alu_ctrl == OP_DIV)),
        .is_div   ((alu_ctrl == OP_DIV) || (alu_ctrl == OP_DIVU)),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (md_done),
        .hi       (hi),
        .lo       (lo)
    );

    // Combinational single-cycle operation mux
    always_comb begin
        sum    = a + b;
        dif    = a - b;
        op_res = '0;
        op_ovf = 1'b0;
        is_md  = 1'b0;
        case (alu_ctrl)
            OP_ADD: begin
                op_res = sum;
                op_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                op_res = dif;
                op_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADDU:  op_res = sum;
            OP_SUBU:  op_res = dif;
            OP_AND:   op_res = a & b;
            OP_OR:    op_res = a | b;
            OP_NOR:   op_res = ~(a | b);
            OP_XOR:   op_res = a ^ b;
            // Relational compare rather than sign of a-b, so overflow cannot corrupt it
            OP_SLT:   op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  op_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:   op_res = b << shamt;
            OP_SRL:   op_res = b >> shamt;
            OP_SRA:   op_res = $signed(b) >>> shamt;
            OP_MFHI:  op_res = hi;
            OP_MFLO:  op_res = lo;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_md = 1'b1;
            default:  op_res = '0;
        endcase
    end

    // Output register next-state: single-cycle result on accept, fixed pattern on mul/div done
    always_comb begin
        result_d    = result_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        if (md_done) begin
            result_d    = '0;
            zero_d      = 1'b1;
            ovf_d       = 1'b0;
            out_valid_d = 1'b1;
        end else if (accept && !is_md) begin
            result_d    = op_res;
            zero_d      = (op_res == '0);
            ovf_d       = op_ovf;
            out_valid_d = 1'b1;
        end
    end

    // Output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed and random checks of alu_muldiv against a 64-bit arithmetic reference model.
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    localparam int W = 32;
    localparam longint MaxS = 64'sd2147483647;
    localparam longint MinS = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, out_valid, zero, ovf;
    logic [4:0]   alu_ctrl, shamt;
    logic [31:0]  a, b, result;
    logic [31:0]  hi_m, lo_m;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    alu_muldiv #(
        .WIDTH  (32),
        .SHAMT_W(5),
        .CTRL_W (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_ctrl (alu_ctrl),
        .a        (a),
        .b        (b),
        .shamt    (shamt),
        .out_valid(out_valid),
        .result   (result),
        .zero     (zero),
        .ovf      (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_single(input logic [4:0] op, input logic [31:0] x,
                                       input logic [31:0] y, input logic [4:0] sh,
                                       output logic [31:0] r, output logic o);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint s;
        logic [31:0] t;
        r = 32'h0;
        o = 1'b0;
        case (op)
            OP_ADD:   begin s = sx + sy; r = s[31:0]; o = (s > MaxS) || (s < MinS); end
            OP_SUB:   begin s = sx - sy; r = s[31:0]; o = (s > MaxS) || (s < MinS); end
            OP_ADDU:  r = x + y;
            OP_SUBU:  r = x - y;
            OP_AND:   r = x & y;
            OP_OR:    r = x | y;
            OP_NOR:   r = ~(x | y);
            OP_XOR:   r = x ^ y;
            OP_SLT:   r = (sx < sy) ? 32'd1 : 32'd0;
            OP_SLTU:  r = (x < y) ? 32'd1 : 32'd0;
            OP_SLL:   begin t = y << sh; r = t; end
            OP_SRL:   begin t = y >> sh; r = t; end
            OP_SRA:   begin s = sy >>> sh; r = s[31:0]; end
            OP_MFHI:  r = hi_m;
            OP_MFLO:  r = lo_m;
            default:  r = 32'h0;
        endcase
    endfunction

    function automatic void ref_md(input logic [4:0] op, input logic [31:0] x,
                                   input logic [31:0] y, output logic [31:0] h,
                                   output logic [31:0] l);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint p;
        longint unsigned ux = {32'h0, x};
        longint unsigned uy = {32'h0, y};
        longint unsigned up;
        h = 32'h0;
        l = 32'h0;
        case (op)
            OP_MULT:  begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
            OP_MULTU: begin up = ux * uy; h = up[63:32]; l = up[31:0]; end
            OP_DIV: begin
                if (y == 32'h0) begin l = 32'hFFFFFFFF; h = x; end
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin l = x; h = 32'h0; end
                else begin p = sx / sy; l = p[31:0]; p = sx % sy; h = p[31:0]; end
            end
            default: begin
                if (y == 32'h0) begin l = 32'hFFFFFFFF; h = x; end
                else begin up = ux / uy; l = up[31:0]; up = ux % uy; h = up[31:0]; end
            end
        endcase
    endfunction

    // Present an op and return #1 after the edge that accepted it
    task automatic issue(input logic [4:0] op, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [4:0] sh);
        int n = 0;
        @(negedge clk);
        alu_ctrl = op; a = ia; b = ib; shamt = sh; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_single(input string tag, input logic [4:0] op, input logic [31:0] ia,
                              input logic [31:0] ib, input logic [4:0] sh);
        logic [31:0] er;
        logic        eo;
        ref_single(op, ia, ib, sh, er, eo);
        issue(op, ia, ib, sh);
        check({tag, "_valid"}, {31'h0, out_valid}, 32'd1);
        check({tag, "_res"}, result, er);
        check({tag, "_zero"}, {31'h0, zero}, {31'h0, (er == 32'h0)});
        check({tag, "_ovf"}, {31'h0, ovf}, {31'h0, eo});
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {31'h0, out_valid}, 32'd0);
    endtask

    task automatic run_md(input string tag, input logic [4:0] op, input logic [31:0] ia,
                          input logic [31:0] ib);
        int lat = 0;
        int nbusy = 0;
        logic [31:0] eh, el;
        ref_md(op, ia, ib, eh, el);
        issue(op, ia, ib, 5'd0);
        // Operands may change freely while the unit is busy
        a = $urandom; b = $urandom;
        while (!out_valid && lat < 100) begin
            if (!in_ready) nbusy++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, W + 1);
        check({tag, "_busy"}, nbusy, W + 1);
        check({tag, "_res"}, result, 32'h0);
        check({tag, "_zero"}, {31'h0, zero}, 32'd1);
        check({tag, "_rdy"}, {31'h0, in_ready}, 32'd1);
        hi_m = eh;
        lo_m = el;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [4:0]  rop;
        logic [31:0] ra, rb;
        int          npulse;

        rst_n = 1'b0; in_valid = 1'b0; alu_ctrl = '0; a = '0; b = '0; shamt = '0;
        hi_m = '0; lo_m = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'h0, out_valid}, 32'd0);
        check("rst_res", result, 32'h0);
        check("rst_zero", {31'h0, zero}, 32'd0);
        check("rst_ovf", {31'h0, ovf}, 32'd0);
        check("rst_rdy", {31'h0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_single("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h1, 5'd0);
        run_single("addu", OP_ADDU, 32'h7FFFFFFF, 32'h1, 5'd0);
        run_single("sub_ovf", OP_SUB, 32'h80000000, 32'h1, 5'd0);
        run_single("subu", OP_SUBU, 32'h80000000, 32'h1, 5'd0);
        run_single("slt", OP_SLT, 32'h80000000, 32'h1, 5'd0);
        run_single("slt_ovf", OP_SLT, 32'h7FFFFFFF, 32'h80000000, 5'd0);
        run_single("sltu", OP_SLTU, 32'h80000000, 32'h1, 5'd0);
        run_single("sra", OP_SRA, 32'h0, 32'hF0000000, 5'd4);
        run_single("srl", OP_SRL, 32'h0, 32'hF0000000, 5'd4);
        run_single("sll", OP_SLL, 32'h0, 32'h0000000F, 5'd31);
        run_single("nor", OP_NOR, 32'h0F0F0000, 32'h000000FF, 5'd0);
        run_single("bad_op", 5'h1F, 32'h12345678, 32'h1, 5'd0);

        run_md("mult", OP_MULT, 32'hFFFFFFFE, 32'h3);
        run_single("mfhi_mult", OP_MFHI, 32'h0, 32'h0, 5'd0);
        run_single("mflo_mult", OP_MFLO, 32'h0, 32'h0, 5'd0);
        run_md("multu", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_single("mfhi_multu", OP_MFHI, 32'h0, 32'h0, 5'd0);
        run_md("div", OP_DIV, 32'hFFFFFFF9, 32'h2);
        run_single("mflo_div", OP_MFLO, 32'h0, 32'h0, 5'd0);
        run_single("mfhi_div", OP_MFHI, 32'h0, 32'h0, 5'd0);
        run_md("divu_z", OP_DIVU, 32'h9, 32'h0);
        run_single("mflo_divz", OP_MFLO, 32'h0, 32'h0, 5'd0);
        run_single("mfhi_divz", OP_MFHI, 32'h0, 32'h0, 5'd0);
        run_md("div_min", OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        run_single("mflo_min", OP_MFLO, 32'h0, 32'h0, 5'd0);
        run_md("div_negz", OP_DIV, 32'hFFFFFFF9, 32'h0);
        run_single("mflo_negz", OP_MFLO, 32'h0, 32'h0, 5'd0);

        // ADD/SUB/XOR queued behind a busy DIV, then issued on consecutive edges
        begin
            logic [31:0] eh, el, er;
            logic        eo;
            int          lat = 0;
            ref_md(OP_DIVU, 32'd100, 32'd7, eh, el);
            issue(OP_DIVU, 32'd100, 32'd7, 5'd0);
            alu_ctrl = OP_ADD; a = 32'd5; b = 32'd6; in_valid = 1'b1;
            while (!out_valid && lat < 100) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("b2b_divlat", lat, W + 1);
            hi_m = eh; lo_m = el;
            @(posedge clk);
            #1;
            ref_single(OP_ADD, 32'd5, 32'd6, 5'd0, er, eo);
            check("b2b_add_v", {31'h0, out_valid}, 32'd1);
            check("b2b_add", result, er);
            alu_ctrl = OP_SUB; a = 32'd3; b = 32'd10;
            @(posedge clk);
            #1;
            ref_single(OP_SUB, 32'd3, 32'd10, 5'd0, er, eo);
            check("b2b_sub_v", {31'h0, out_valid}, 32'd1);
            check("b2b_sub", result, er);
            alu_ctrl = OP_XOR; a = 32'hA5A5A5A5; b = 32'hFFFF0000;
            @(posedge clk);
            #1;
            ref_single(OP_XOR, 32'hA5A5A5A5, 32'hFFFF0000, 5'd0, er, eo);
            check("b2b_xor_v", {31'h0, out_valid}, 32'd1);
            check("b2b_xor", result, er);
            in_valid = 1'b0;
            run_single("b2b_mflo", OP_MFLO, 32'h0, 32'h0, 5'd0);
        end

        // Reset in the middle of a MULT: no completion pulse, HI/LO cleared
        issue(OP_MULT, 32'h1234, 32'h5678, 5'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mrst_valid", {31'h0, out_valid}, 32'd0);
        check("mrst_res", result, 32'h0);
        check("mrst_zero", {31'h0, zero}, 32'd0);
        check("mrst_ovf", {31'h0, ovf}, 32'd0);
        check("mrst_rdy", {31'h0, in_ready}, 32'd1);
        hi_m = '0; lo_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
        npulse = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) npulse++;
        end
        check("mrst_nopulse", npulse, 0);
        run_single("mrst_mfhi", OP_MFHI, 32'h0, 32'h0, 5'd0);
        run_single("mrst_mflo", OP_MFLO, 32'h0, 32'h0, 5'd0);

        for (int i = 0; i < 80; i++) begin
            rop = 5'($urandom_range(0, 31));
            ra = pick();
            rb = pick();
            if (rop == OP_MULT || rop == OP_MULTU || rop == OP_DIV || rop == OP_DIVU)
                run_md("rnd_md", rop, ra, rb);
            else
                run_single("rnd", rop, ra, rb, 5'($urandom_range(0, 31)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
